i2c_apb_multi_hub: RTL and testbench

- Parametrised successor to the single-channel APB-to-I2C hookup.
- One upstream APB slave (driven by the BD APB master) fans out to NUM_CH i2c_master_top instances through registered downstream APB transfers.
- Adds per-transfer timeout with error response, decode errors, and an interrupt aggregator (pending/mask/raw registers) producing a single irq to the BD intr_in.

---
 rtl/i2c_apb_multi_hub.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_apb_multi_hub.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_multi_hub.sv
// Purpose: APB slave that fans out to NUM_CH downstream I2C APB ports and hosts hub IRQ registers.
// Latency: channel access 4 cycles counting the setup cycle (ready already high); hub register or decode error 2 cycles.
// Backpressure: upstream waits on apb_ready until ch_ready or timeout; one transfer in flight, no queuing.
module i2c_apb_multi_hub #(
  parameter int NUM_CH       = 4,
  parameter int CH_ADDR_BITS = 8,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    apb_sel,
  input  logic                    apb_en,
  input  logic                    apb_write,
  input  logic [31:0]             apb_addr,
  input  logic [31:0]             apb_wdata,
  output logic                    apb_ready,
  output logic [31:0]             apb_rdata,
  output logic                    apb_slverr,
  output logic [NUM_CH-1:0]       ch_sel,
  output logic                    ch_en,
  output logic                    ch_write,
  output logic [CH_ADDR_BITS-1:0] ch_addr,
  output logic [31:0]             ch_wdata,
  input  logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH*32-1:0]    ch_rdata,
  input  logic [NUM_CH-1:0]       ch_irq,
  output logic                    irq
);

  typedef enum logic [1:0] {IDLE, CSETUP, CACCESS, DONE} state_t;

  localparam logic [3:0] HUB_SLOT = 4'hF;

  state_t                  state_q, state_d;
  logic [3:0]              slot_q, slot_d;
  logic                    write_q, write_d;
  logic [CH_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    ready_d, err_d, en_d;
  logic [31:0]             rdata_d;
  logic [NUM_CH-1:0]       sel_d;

  logic [NUM_CH-1:0]       pend_q, mask_q, irq_prev_q;
  logic [NUM_CH-1:0]       w1c, rise;

  logic                    setup, hub_acc;
  logic [3:0]              up_slot;
  logic [7:0]              hub_off;
  logic [31:0]             hub_rdata;
  logic [NUM_CH-1:0]       up_oh, slot_oh;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    unused_addr_hi;

  // A transfer only starts from a genuine setup phase, so a lingering access phase never retriggers.
  assign setup          = apb_sel & ~apb_en;
  assign up_slot        = apb_addr[CH_ADDR_BITS+3:CH_ADDR_BITS];
  assign hub_off        = apb_addr[7:0];
  assign hub_acc        = (state_q == IDLE) && setup && (up_slot == HUB_SLOT);
  assign unused_addr_hi = &{1'b0, apb_addr[31:CH_ADDR_BITS+4]};

  // Downstream address/data/direction come straight from the latched request, stable for the whole transfer.
  assign ch_write = write_q;
  assign ch_addr  = addr_q;
  assign ch_wdata = wdata_q;

  assign rise = ch_irq & ~irq_prev_q;
  assign w1c  = (hub_acc && apb_write && (hub_off == 8'h00)) ? apb_wdata[NUM_CH-1:0] : '0;

  // Slot decode: one-hot of the incoming slot, and ready/rdata mux for the latched slot.
  always_comb begin
    up_oh     = '0;
    slot_oh   = '0;
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (up_slot == 4'(k)) begin
        up_oh[k] = 1'b1;
      end
      if (slot_q == 4'(k)) begin
        slot_oh[k] = 1'b1;
        sel_ready  = ch_ready[k];
        sel_rdata  = ch_rdata[32*k +: 32];
      end
    end
  end

  // Hub register read mux; unmapped offsets and unused upper bits read 0.
  always_comb begin
    hub_rdata = '0;
    case (hub_off)
      8'h00:   hub_rdata[NUM_CH-1:0] = pend_q;
      8'h04:   hub_rdata[NUM_CH-1:0] = mask_q;
      8'h08:   hub_rdata[NUM_CH-1:0] = ch_irq;
      8'h0C:   hub_rdata[7:0]        = {4'(NUM_CH), 4'h1};
      default: hub_rdata             = '0;
    endcase
  end

  // Next-state and next-output logic; outputs are computed for the state being entered so the registers line up with it.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    sel_d   = '0;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          slot_d  = up_slot;
          write_d = apb_write;
          addr_d  = apb_addr[CH_ADDR_BITS-1:0];
          wdata_d = apb_wdata;
          if (|up_oh) begin
            state_d = CSETUP;
            sel_d   = up_oh;
          end else if (up_slot == HUB_SLOT) begin
            state_d = DONE;
            ready_d = 1'b1;
            rdata_d = hub_rdata;
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      CSETUP: begin
        state_d = CACCESS;
        sel_d   = slot_oh;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      CACCESS: begin
        if (sel_ready) begin
          state_d = DONE;
          ready_d = 1'b1;
          rdata_d = write_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          // Last allowed access cycle passed without ready: abandon the channel.
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          sel_d = slot_oh;
          en_d  = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      apb_ready  <= 1'b0;
      apb_rdata  <= '0;
      apb_slverr <= 1'b0;
      ch_sel     <= '0;
      ch_en      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      apb_ready  <= ready_d;
      apb_rdata  <= rdata_d;
      apb_slverr <= err_d;
      ch_sel     <= sel_d;
      ch_en      <= en_d;
    end
  end

  // Interrupt aggregator: edge-detected pending bits (set beats W1C), mask, registered irq.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      irq        <= 1'b0;
    end else begin
      irq_prev_q <= ch_irq;
      pend_q     <= (pend_q & ~w1c) | rise;
      if (hub_acc && apb_write && (hub_off == 8'h04)) begin
        mask_q <= apb_wdata[NUM_CH-1:0];
      end
      irq <= |(pend_q & mask_q);
    end
  end

endmodule

// File: tb/tb_i2c_apb_multi_hub.sv
// Bench for i2c_apb_multi_hub with NUM_CH=4, CH_ADDR_BITS=8, TIMEOUT_CYC=16.
// Latency figures count the setup cycle as cycle 1, so "ready in cycle N" means N-1 edges after setup.
module tb_i2c_apb_multi_hub;
  localparam int NUM_CH = 4;
  localparam int CH_ADDR_BITS = 8;
  localparam int TIMEOUT_CYC = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          apb_sel, apb_en, apb_write;
  logic [31:0]   apb_addr, apb_wdata;
  logic          apb_ready, apb_slverr;
  logic [31:0]   apb_rdata;
  logic [3:0]    ch_sel;
  logic          ch_en, ch_write;
  logic [7:0]    ch_addr;
  logic [31:0]   ch_wdata;
  logic [3:0]    ch_ready;
  logic [127:0]  ch_rdata;
  logic [3:0]    ch_irq;
  logic          irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the hub's interrupt state.
  logic [3:0] m_pend, m_mask;

  i2c_apb_multi_hub #(.NUM_CH(NUM_CH), .CH_ADDR_BITS(CH_ADDR_BITS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr),
    .ch_sel(ch_sel), .ch_en(ch_en), .ch_write(ch_write), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata), .ch_irq(ch_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change the interrupt lines and let the hub see the new level.
  task automatic irq_drive(input logic [3:0] v);
    m_pend = m_pend | (v & ~ch_irq);
    ch_irq = v;
    tick();
    tick();
  endtask

  // One upstream APB transfer with a downstream responder whose ready rises after dly access cycles (dly>=16: never).
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int dly, input logic [127:0] slices, input logic [3:0] irq_v, input logic drop,
                          output logic [31:0] rd, output logic err, output int lat,
                          output logic [3:0] sel_or, output int sel_cyc, output int en_cyc,
                          output logic bus_ok, output logic rdy_after);
    int tgt;
    int en_cnt;
    logic done;
    tgt = int'(addr[11:8]);
    en_cnt = 0;
    done = 1'b0;
    rd = '0; err = 1'b0; lat = -1; sel_or = '0; sel_cyc = 0; en_cyc = 0; bus_ok = 1'b1;
    apb_sel = 1'b1; apb_en = 1'b0; apb_addr = addr; apb_write = wr; apb_wdata = wd;
    ch_rdata = slices;
    ch_irq = irq_v;
    for (int c = 0; c < 4; c++) ch_ready[c] = (c == tgt) ? (dly == 0) : 1'b1;
    for (int i = 1; i <= 40 && !done; i++) begin
      tick();
      apb_en = 1'b1;
      if (drop) begin
        apb_sel = 1'b0;
        apb_en = 1'b0;
      end
      if (ch_sel != 4'b0) begin
        sel_cyc++;
        sel_or |= ch_sel;
        if (ch_write !== wr || ch_addr !== addr[7:0] || ch_wdata !== wd) bus_ok = 1'b0;
      end
      if (ch_en) begin
        en_cyc++;
        en_cnt++;
      end
      if (apb_ready) begin
        rd = apb_rdata;
        err = apb_slverr;
        lat = i;
        done = 1'b1;
      end
      for (int c = 0; c < 4; c++) ch_ready[c] = (c == tgt) ? (dly == 0 || en_cnt > dly) : 1'b1;
    end
    apb_sel = 1'b0;
    apb_en = 1'b0;
    tick();
    rdy_after = apb_ready;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({apb_ready, apb_slverr, apb_rdata, ch_sel, ch_en, ch_write, ch_addr, ch_wdata, irq} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h sel=%b en=%b wr=%b addr=%h wd=%h irq=%b, want all 0",
               apb_ready, apb_slverr, apb_rdata, ch_sel, ch_en, ch_write, ch_addr, ch_wdata, irq);
    end
    resetn = 1'b1;
    tick();
    n_vec++;
    if ({apb_ready, ch_sel, ch_en, irq} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got rdy=%b sel=%b en=%b irq=%b, want 0", apb_ready, ch_sel, ch_en, irq);
    end
  endtask

  task automatic test_ch_write();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    apb_xfer(32'h204, 1'b1, 32'hA5, 0, {4{32'h1234_5678}}, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (so !== 4'b0100) begin n_err++; $display("FAIL wr_sel: got %b want 0100", so); end
    n_vec++; if (sc != 2) begin n_err++; $display("FAIL wr_sel_cycles: got %0d want 2", sc); end
    n_vec++; if (bo !== 1'b1) begin n_err++; $display("FAIL wr_bus: addr/wdata/write wrong while selected (got %b)", bo); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL wr_latency: got %0d edges want 3", lat); end
    n_vec++; if (err !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL wr_resp: got err=%b rd=%h want 0/0", err, rd); end
    n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL wr_ready_pulse: ready still %b after one cycle", ra); end
  endtask

  task automatic test_ch_read_wait();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    apb_xfer(32'h110, 1'b0, 32'h0, 3, {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0000},
             ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_vec++; if (so !== 4'b0010) begin n_err++; $display("FAIL rd_sel: got %b want 0010", so); end
    n_vec++; if (ec != 4 || lat != 6) begin n_err++; $display("FAIL rd_wait: got en=%0d lat=%0d want 4/6", ec, lat); end
    n_vec++; if (err !== 1'b0 || ra !== 1'b0) begin n_err++; $display("FAIL rd_resp: got err=%b ready_after=%b want 0/0", err, ra); end
  endtask

  task automatic test_decode_err();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    apb_xfer(32'h500, 1'b0, 32'h0, 0, {4{32'hFFFF_FFFF}}, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (so !== 4'b0 || ec != 0) begin n_err++; $display("FAIL dec_sel: got sel=%b en=%0d want none", so, ec); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL dec_latency: got %0d want 1", lat); end
    n_vec++; if (err !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL dec_resp: got err=%b rd=%h want 1/0", err, rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    apb_xfer(32'h300, 1'b1, 32'h55, 255, {4{32'hFFFF_FFFF}}, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (ec != TIMEOUT_CYC) begin n_err++; $display("FAIL to_en_cycles: got %0d want %0d", ec, TIMEOUT_CYC); end
    n_vec++; if (err !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL to_resp: got err=%b rd=%h want 1/0", err, rd); end
    n_vec++; if (lat != TIMEOUT_CYC + 2) begin n_err++; $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT_CYC + 2); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    irq_drive(4'b0100);
    irq_drive(4'b0000);
    apb_xfer(32'hF04, 1'b1, 32'h4, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    m_mask = 4'h4;
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    n_vec++; if (lat != 1 || err !== 1'b0) begin n_err++; $display("FAIL hub_resp: got lat=%0d err=%b want 1/0", lat, err); end
    apb_xfer(32'hF00, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== {28'h0, m_pend}) begin n_err++; $display("FAIL pend_read: got %h want %h", rd, {28'h0, m_pend}); end
    apb_xfer(32'hF00, 1'b1, 32'h4, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    m_pend = m_pend & ~4'h4;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    // W1C of bit 2 in the very cycle ch_irq[2] rises: the new edge must survive.
    irq_drive(4'b0100);
    irq_drive(4'b0000);
    apb_xfer(32'hF00, 1'b1, 32'h4, 0, '0, 4'b0100, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    m_pend = (m_pend & ~4'h4) | 4'h4;
    apb_xfer(32'hF00, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'h4) begin n_err++; $display("FAIL set_beats_w1c: got %h want 4", rd); end
    apb_xfer(32'hF0C, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'h41) begin n_err++; $display("FAIL info: got %h want 41", rd); end
    apb_xfer(32'hF08, 1'b1, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    apb_xfer(32'hF08, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'h4) begin n_err++; $display("FAIL raw_read: got %h want 4", rd); end
    apb_xfer(32'hF10, 1'b1, 32'hFFFF_FFFF, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    apb_xfer(32'hF10, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'h0 || err !== 1'b0) begin n_err++; $display("FAIL unmapped: got rd=%h err=%b want 0/0", rd, err); end
    irq_drive(4'b0000);
  endtask

  // Randomised mix of channel, hub and decode-error transfers checked against plain rules.
  task automatic test_back_to_back();
    logic [31:0] rd, wd, addr, exp_rd; logic err, bo, ra, wr, exp_err, drop; int lat, sc, ec, dly, exp_lat, exp_en;
    logic [3:0] so, exp_sel, slot; logic [127:0] slices; int r;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) irq_drive(4'($urandom_range(0, 15)));
      r = $urandom_range(0, 9);
      if (r < 6) slot = 4'($urandom_range(0, 3));
      else if (r < 8) slot = 4'hF;
      else slot = 4'($urandom_range(4, 14));
      addr = {20'h0, slot, (slot == 4'hF) ? 8'($urandom_range(0, 4) * 4) : 8'($urandom_range(0, 255))};
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      slices = {$urandom, $urandom, $urandom, $urandom};
      dly = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 4);
      drop = 1'($urandom_range(0, 3) == 0);
      exp_sel = '0; exp_en = 0; exp_err = 1'b0; exp_rd = '0; exp_lat = 1;
      if (slot < 4) begin
        exp_sel = 4'b0001 << slot;
        if (dly >= TIMEOUT_CYC) begin
          exp_err = 1'b1; exp_en = TIMEOUT_CYC; exp_lat = TIMEOUT_CYC + 2;
        end else begin
          exp_en = dly + 1; exp_lat = dly + 3;
          exp_rd = wr ? 32'h0 : slices[32*int'(slot) +: 32];
        end
      end else if (slot == 4'hF) begin
        case (addr[7:0])
          8'h00: exp_rd = {28'h0, m_pend};
          8'h04: exp_rd = {28'h0, m_mask};
          8'h08: exp_rd = {28'h0, ch_irq};
          8'h0C: exp_rd = 32'h41;
          default: exp_rd = 32'h0;
        endcase
      end else begin
        exp_err = 1'b1;
      end
      apb_xfer(addr, wr, wd, dly, slices, ch_irq, drop, rd, err, lat, so, sc, ec, bo, ra);
      if (slot == 4'hF && wr && addr[7:0] == 8'h04) m_mask = wd[3:0];
      if (slot == 4'hF && wr && addr[7:0] == 8'h00) m_pend = m_pend & ~wd[3:0];
      n_vec++;
      if (rd !== exp_rd || err !== exp_err) begin
        n_err++; $display("FAIL rnd_resp[%0d] addr=%h wr=%b: got rd=%h err=%b want rd=%h err=%b", it, addr, wr, rd, err, exp_rd, exp_err);
      end
      n_vec++;
      if (lat != exp_lat || so !== exp_sel || ec != exp_en || bo !== 1'b1 || ra !== 1'b0) begin
        n_err++; $display("FAIL rnd_timing[%0d] addr=%h: got lat=%0d sel=%b en=%0d bus=%b ra=%b want lat=%0d sel=%b en=%0d bus=1 ra=0",
                          it, addr, lat, so, ec, bo, ra, exp_lat, exp_sel, exp_en);
      end
      n_vec++;
      if (irq !== |(m_pend & m_mask)) begin
        n_err++; $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq, |(m_pend & m_mask));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err, bo, ra; int lat, sc, ec; logic [3:0] so;
    irq_drive(4'b0000);
    apb_xfer(32'hF04, 1'b1, 32'hF, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    m_mask = 4'hF;
    apb_sel = 1'b1; apb_en = 1'b0; apb_addr = 32'h208; apb_write = 1'b1; apb_wdata = 32'h77;
    ch_ready = 4'b1011;
    tick();
    apb_en = 1'b1;
    tick();
    tick();
    n_vec++; if (ch_en !== 1'b1 || ch_sel !== 4'b0100) begin n_err++; $display("FAIL rst_pre: got sel=%b en=%b want 0100/1", ch_sel, ch_en); end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (ch_sel !== 4'b0 || ch_en !== 1'b0 || apb_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_async: got sel=%b en=%b rdy=%b want 0", ch_sel, ch_en, apb_ready);
    end
    apb_sel = 1'b0; apb_en = 1'b0; ch_ready = 4'b0;
    tick();
    n_vec++; if (apb_ready !== 1'b0 || ch_en !== 1'b0) begin n_err++; $display("FAIL rst_hold: got rdy=%b en=%b want 0", apb_ready, ch_en); end
    resetn = 1'b1;
    m_mask = 4'h0; m_pend = 4'h0;
    tick();
    apb_xfer(32'hF04, 1'b0, 32'h0, 0, '0, ch_irq, 1'b0, rd, err, lat, so, sc, ec, bo, ra);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_mask: got %h want 0", rd); end
  endtask

  initial begin
    resetn = 1'b0; apb_sel = 1'b0; apb_en = 1'b0; apb_write = 1'b0; apb_addr = '0; apb_wdata = '0;
    ch_ready = '0; ch_rdata = '0; ch_irq = '0; m_pend = '0; m_mask = '0;
    test_reset();
    test_ch_write();
    test_ch_read_wait();
    test_decode_err();
    test_timeout();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
